mips_instr_encoder: RTL and testbench
=====================================

MIPS_INSTR_ENCODER -- requirements
Module: mips_instr_encoder

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-high, named as listed below.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 in_valid  in  1  request carries a valid instruction description.
REQ-005 in_ready  out  1  block accepts the request this cycle.
REQ-006 in_mnem  in  5  mnemonic code, taken from the shared package enumeration.
REQ-007 in_rs, in_rt, in_rd, in_shamt  in  5 each  register and shift-amount fields.
REQ-008 in_imm  in  32  immediate; bits used depend on the mnemonic (REQ-016).
REQ-009 addr_clr  in  1  resets the emit address to 0.
REQ-010 out_valid  out  1  out_instr and out_addr hold a valid word.
REQ-011 out_ready  in  1  consumer takes the word this cycle.
REQ-012 out_instr  out  32  encoded MIPS instruction word.
REQ-013 out_addr  out  10  word address of out_instr.
REQ-014 err  out  1  one-cycle pulse when an unsupported mnemonic is accepted.

Function
REQ-015 The block SHALL accept a request when in_valid and in_ready are both high in the same cycle.
REQ-016 Encodings SHALL be as follows.
- R-type: op=0; funct values: add 0x20, addu 0x21, sub 0x22, subu 0x23, and 0x24, or 0x25, slt 0x2A, sltu 0x2B, sll 0x00, srl 0x02, sllv 0x04, srlv 0x06.
- I-type: addi 0x08, ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B, beq 0x04; the immediate field is imm[15:0], truncated without a flag.
- J-type: j 0x02, jal 0x03; the target field is imm[25:0].
- nop SHALL encode as 0x00000000.
REQ-017 Pseudo li SHALL expand by the value of imm[31:16].
- If imm[31:16]==0: a single word, ori rt,$0,imm[15:0].
- Otherwise two words: lui rt,imm[31:16], then ori rt,rt,imm[15:0].
REQ-018 The state machine SHALL have three states.
- EMPTY: out_valid=0.
- HOLD: last or only word presented.
- HOLD_HI: lui presented, ori pending.
REQ-019 Transitions SHALL be as follows.
- EMPTY to HOLD on accepting a single-word request.
- EMPTY to HOLD_HI on accepting a two-word li.
- HOLD_HI to HOLD on an out handshake; out_instr becomes the pending ori.
- HOLD to EMPTY on an out handshake with no new accept.
- HOLD to HOLD or HOLD_HI on an out handshake with a simultaneous accept.
REQ-020 in_ready SHALL equal (state==EMPTY) | (state==HOLD & out_ready).
- This gives one word per cycle when the consumer does not stall.
REQ-021 Latency SHALL be one cycle: a word accepted in cycle N is presented with out_valid=1 in cycle N+1.
REQ-022 out_instr and out_addr SHALL stay stable while out_valid=1 and out_ready=0.
REQ-023 out_addr SHALL increment by 1 on each out handshake and wrap from 1023 to 0.
REQ-024 addr_clr SHALL set the address to 0 on the next edge.
- If addr_clr coincides with a handshake, addr_clr wins.
- A word already presented keeps its address.
REQ-025 An unsupported mnemonic SHALL be consumed without emitting a word.
- err=1 for exactly the cycle after the accept.
- The state is unchanged by that request.

Reset
REQ-026 While rst is high the block SHALL hold these values.
- state=EMPTY, out_valid=0, out_instr=0, out_addr=0, err=0.
- in_ready=0 during the reset cycle, 1 after it.
REQ-027 Reset asserted in HOLD_HI SHALL discard the pending ori word.

Structure
REQ-028 The mnemonic enumeration and the opcode/funct constants SHALL live in a shared package, mips_isa_pkg, which the control decoder also uses.
REQ-029 Encoding SHALL be a combinational sub-module, instr_pack (mnemonic plus fields to word).
- The FSM, address counter and output registers SHALL live in the top module.

Verification
REQ-030 add rd=3,rs=1,rt=2 -> out_instr=0x00221820, out_addr=0, out_valid one cycle after accept.
REQ-031 li rt=8, imm=0x12345678 -> 0x3C081234 then 0x35085678 at consecutive addresses; in_ready=0 while HOLD_HI.
REQ-032 lw rt=4, rs=29, imm=8 and jal imm=0xC00, sent back-to-back with out_ready=1 -> 0x8FA40008, then 0x0C000C00 the next cycle.
REQ-033 out_ready held low for 3 cycles -> word and address stable, no accept, and the handshake completes on cycle 4.
REQ-034 1024 nops -> addresses run 0 to 1023 then wrap to 0; addr_clr together with a handshake -> next address 0.
REQ-035 Unsupported mnemonic 0x1F -> err pulses one cycle, no out_valid; rst asserted in HOLD_HI -> no ori emitted.

Source files
------------

// File: rtl/mips_isa_pkg.sv
// mips_isa_pkg: mnemonic codes, opcode/funct constants and field packers shared by the encoder.
package mips_isa_pkg;
  typedef enum logic [4:0] {
    M_NOP, M_ADD, M_ADDU, M_SUB, M_SUBU, M_AND, M_OR, M_SLT, M_SLTU,
    M_SLL, M_SRL, M_SLLV, M_SRLV, M_ADDI, M_ORI, M_LUI, M_LW, M_SW,
    M_BEQ, M_J, M_JAL, M_LI
  } mnem_e;
  typedef enum logic [1:0] {EMPTY, HOLD, HOLD_HI} state_e;
  localparam logic [5:0] F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23;
  localparam logic [5:0] F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A, F_SLTU = 6'h2B;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SLLV = 6'h04, F_SRLV = 6'h06;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_ORI = 6'h0D, OP_LUI = 6'h0F, OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2B, OP_BEQ = 6'h04, OP_J = 6'h02, OP_JAL = 6'h03;
  function automatic logic [31:0] r_type(logic [4:0] rs, rt, rd, sh, logic [5:0] f);
    return {6'd0, rs, rt, rd, sh, f};
  endfunction
  function automatic logic [31:0] i_type(logic [5:0] op, logic [4:0] rs, rt, logic [15:0] im);
    return {op, rs, rt, im};
  endfunction
  function automatic logic [31:0] j_type(logic [5:0] op, logic [25:0] t);
    return {op, t};
  endfunction
endpackage

// File: rtl/mips_instr_encoder_if.sv
// mips_instr_encoder_if: request, emit and control signals of the instruction encoder.
interface mips_instr_encoder_if;
  logic in_valid, in_ready;
  logic [4:0] in_mnem, in_rs, in_rt, in_rd, in_shamt;
  logic [31:0] in_imm;
  logic addr_clr;
  logic out_valid, out_ready;
  logic [31:0] out_instr;
  logic [9:0] out_addr;
  logic err;
  modport master (
    output in_valid, in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm, addr_clr, out_ready,
    input in_ready, out_valid, out_instr, out_addr, err
  );
  modport slave (
    input in_valid, in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm, addr_clr, out_ready,
    output in_ready, out_valid, out_instr, out_addr, err
  );
endinterface

// File: rtl/instr_pack.sv
// instr_pack: combinational mnemonic-plus-fields to MIPS word, with li split into lui/ori.
module instr_pack
  import mips_isa_pkg::*;
(
  input  logic [4:0]  mnem,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic [31:0] lo,
  output logic        two,
  output logic        bad
);
  always_comb begin
    word = '0;
    lo = i_type(OP_ORI, rt, rt, imm[15:0]);
    two = 1'b0;
    bad = 1'b0;
    case (mnem)
      M_NOP:  word = '0;
      M_ADD:  word = r_type(rs, rt, rd, shamt, F_ADD);
      M_ADDU: word = r_type(rs, rt, rd, shamt, F_ADDU);
      M_SUB:  word = r_type(rs, rt, rd, shamt, F_SUB);
      M_SUBU: word = r_type(rs, rt, rd, shamt, F_SUBU);
      M_AND:  word = r_type(rs, rt, rd, shamt, F_AND);
      M_OR:   word = r_type(rs, rt, rd, shamt, F_OR);
      M_SLT:  word = r_type(rs, rt, rd, shamt, F_SLT);
      M_SLTU: word = r_type(rs, rt, rd, shamt, F_SLTU);
      M_SLL:  word = r_type(rs, rt, rd, shamt, F_SLL);
      M_SRL:  word = r_type(rs, rt, rd, shamt, F_SRL);
      M_SLLV: word = r_type(rs, rt, rd, shamt, F_SLLV);
      M_SRLV: word = r_type(rs, rt, rd, shamt, F_SRLV);
      M_ADDI: word = i_type(OP_ADDI, rs, rt, imm[15:0]);
      M_ORI:  word = i_type(OP_ORI, rs, rt, imm[15:0]);
      M_LUI:  word = i_type(OP_LUI, rs, rt, imm[15:0]);
      M_LW:   word = i_type(OP_LW, rs, rt, imm[15:0]);
      M_SW:   word = i_type(OP_SW, rs, rt, imm[15:0]);
      M_BEQ:  word = i_type(OP_BEQ, rs, rt, imm[15:0]);
      M_J:    word = j_type(OP_J, imm[25:0]);
      M_JAL:  word = j_type(OP_JAL, imm[25:0]);
      M_LI: begin
        two = |imm[31:16];
        word = |imm[31:16] ? i_type(OP_LUI, 5'd0, rt, imm[31:16]) : i_type(OP_ORI, 5'd0, rt, imm[15:0]);
      end
      default: bad = 1'b1;
    endcase
  end
endmodule

// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder: accepts instruction descriptions and emits encoded words with word addresses.
module mips_instr_encoder
  import mips_isa_pkg::*;
(
  input logic clk,
  input logic rst,
  mips_instr_encoder_if.slave bus
);
  state_e state;
  logic [31:0] word, lo, pend;
  logic two, bad, acc, hs, load, clr_pend;
  instr_pack u_pack (
    .mnem(bus.in_mnem), .rs(bus.in_rs), .rt(bus.in_rt), .rd(bus.in_rd),
    .shamt(bus.in_shamt), .imm(bus.in_imm), .word(word), .lo(lo), .two(two), .bad(bad)
  );
  assign bus.in_ready = !rst && (state == EMPTY || (state == HOLD && bus.out_ready));
  assign bus.out_valid = state != EMPTY;
  assign acc = bus.in_valid && bus.in_ready;
  assign hs = bus.out_valid && bus.out_ready;
  assign load = acc && !bad;
  // a clear arriving while a word is held is deferred so the held word keeps its address
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      bus.out_instr <= '0;
      bus.out_addr <= '0;
      bus.err <= 1'b0;
      pend <= '0;
      clr_pend <= 1'b0;
    end else begin
      bus.err <= acc && bad;
      if (load) begin
        bus.out_instr <= word;
        pend <= lo;
        state <= two ? HOLD_HI : HOLD;
      end else if (hs) begin
        bus.out_instr <= state == HOLD_HI ? pend : bus.out_instr;
        state <= state == HOLD_HI ? HOLD : EMPTY;
      end
      if (bus.addr_clr && (hs || state == EMPTY)) begin
        bus.out_addr <= '0;
        clr_pend <= 1'b0;
      end else if (bus.addr_clr) begin
        clr_pend <= 1'b1;
      end else if (hs) begin
        bus.out_addr <= clr_pend ? 10'd0 : bus.out_addr + 10'd1;
        clr_pend <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mips_instr_encoder.sv
// tb_mips_instr_encoder: directed and random checks against a queue-based reference of the emitted word stream.
module tb_mips_instr_encoder;
  import mips_isa_pkg::*;
  logic clk, rst;
  mips_instr_encoder_if bus ();
  mips_instr_encoder dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int errors = 0, checks = 0;
  logic [31:0] q[$];
  int na = 0, ha = 0;
  logic e_err = 1'b0, live = 1'b0;
  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  function automatic logic [31:0] rw(int s, int t, int d, int h, int f);
    return 32'((s << 21) | (t << 16) | (d << 11) | (h << 6) | f);
  endfunction
  function automatic logic [31:0] iw(int op, int s, int t, int im);
    return 32'((op << 26) | (s << 21) | (t << 16) | (im & 'hFFFF));
  endfunction
  function automatic logic [31:0] jw(int op, int t);
    return 32'((op << 26) | (t & 'h3FFFFFF));
  endfunction
  // reference encoding written from the instruction tables: number of words and the words
  task automatic enc(input logic [4:0] m, input int s, t, d, h, input logic [31:0] im,
                     output int n, output logic [31:0] w0, output logic [31:0] w1);
    n = 1;
    w0 = 32'd0;
    w1 = 32'd0;
    case (m)
      M_NOP:  w0 = 32'd0;
      M_ADD:  w0 = rw(s, t, d, h, 'h20);
      M_ADDU: w0 = rw(s, t, d, h, 'h21);
      M_SUB:  w0 = rw(s, t, d, h, 'h22);
      M_SUBU: w0 = rw(s, t, d, h, 'h23);
      M_AND:  w0 = rw(s, t, d, h, 'h24);
      M_OR:   w0 = rw(s, t, d, h, 'h25);
      M_SLT:  w0 = rw(s, t, d, h, 'h2A);
      M_SLTU: w0 = rw(s, t, d, h, 'h2B);
      M_SLL:  w0 = rw(s, t, d, h, 'h00);
      M_SRL:  w0 = rw(s, t, d, h, 'h02);
      M_SLLV: w0 = rw(s, t, d, h, 'h04);
      M_SRLV: w0 = rw(s, t, d, h, 'h06);
      M_ADDI: w0 = iw('h08, s, t, int'(im));
      M_ORI:  w0 = iw('h0D, s, t, int'(im));
      M_LUI:  w0 = iw('h0F, s, t, int'(im));
      M_LW:   w0 = iw('h23, s, t, int'(im));
      M_SW:   w0 = iw('h2B, s, t, int'(im));
      M_BEQ:  w0 = iw('h04, s, t, int'(im));
      M_J:    w0 = jw('h02, int'(im));
      M_JAL:  w0 = jw('h03, int'(im));
      M_LI: begin
        if (im / 65536 == 0) w0 = iw('h0D, 0, t, int'(im));
        else begin
          n = 2;
          w0 = iw('h0F, 0, t, int'(im / 65536));
          w1 = iw('h0D, t, t, int'(im % 65536));
        end
      end
      default: n = 0;
    endcase
  endtask
  // queue holds the presented word plus any word still pending behind it
  task automatic step();
    int n;
    logic [31:0] w0, w1;
    logic ir_e, hs, acc, pres;
    ir_e = !rst && (q.size() == 0 || (q.size() == 1 && bus.out_ready));
    chk("in_ready", 32'(bus.in_ready), 32'(ir_e));
    if (live) begin
      chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
      chk("err", 32'(bus.err), 32'(e_err));
      if (q.size() != 0) begin
        chk("out_instr", bus.out_instr, q[0]);
        chk("out_addr", 32'(bus.out_addr), 32'(ha));
      end
    end
    if (rst) begin
      q.delete();
      na = 0;
      e_err = 1'b0;
      live = 1'b1;
      return;
    end
    enc(bus.in_mnem, int'(bus.in_rs), int'(bus.in_rt), int'(bus.in_rd), int'(bus.in_shamt), bus.in_imm, n, w0, w1);
    hs = q.size() != 0 && bus.out_ready;
    acc = bus.in_valid && ir_e;
    pres = 1'b0;
    if (bus.addr_clr) na = 0;
    if (hs) begin
      void'(q.pop_front());
      pres = 1'b1;
    end
    if (q.size() == 0 && acc && n > 0) pres = 1'b1;
    e_err = acc && n == 0;
    if (acc && n > 0) begin
      q.push_back(w0);
      if (n == 2) q.push_back(w1);
    end
    if (pres && q.size() != 0) begin
      ha = na;
      na = (na + 1) % 1024;
    end
  endtask
  task automatic cyc();
    @(negedge clk);
    step();
    @(posedge clk);
    #1;
  endtask
  task automatic put(logic v, logic [4:0] m, logic [4:0] s, t, d, h, logic [31:0] im);
    bus.in_valid = v;
    bus.in_mnem = m;
    bus.in_rs = s;
    bus.in_rt = t;
    bus.in_rd = d;
    bus.in_shamt = h;
    bus.in_imm = im;
  endtask
  initial begin
    rst = 1'b1;
    bus.addr_clr = 1'b0;
    bus.out_ready = 1'b0;
    put(1'b0, M_NOP, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    cyc();
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_instr", bus.out_instr, 32'd0);
    chk("rst_addr", 32'(bus.out_addr), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd0);
    cyc();
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(bus.in_ready), 32'd1);
    put(1'b1, M_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 32'd0);
    cyc();
    put(1'b0, M_NOP, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    chk("add_valid", 32'(bus.out_valid), 32'd1);
    chk("add_instr", bus.out_instr, 32'h00221820);
    chk("add_addr", 32'(bus.out_addr), 32'd0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("stall_instr", bus.out_instr, 32'h00221820);
      chk("stall_addr", 32'(bus.out_addr), 32'd0);
      chk("stall_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    cyc();
    chk("stall_done", 32'(bus.out_valid), 32'd0);
    put(1'b1, M_LI, 5'd0, 5'd8, 5'd0, 5'd0, 32'h12345678);
    cyc();
    put(1'b0, M_NOP, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    chk("li_hi", bus.out_instr, 32'h3C081234);
    chk("li_hi_addr", 32'(bus.out_addr), 32'd1);
    chk("li_hi_ready", 32'(bus.in_ready), 32'd0);
    cyc();
    chk("li_lo", bus.out_instr, 32'h35085678);
    chk("li_lo_addr", 32'(bus.out_addr), 32'd2);
    cyc();
    put(1'b1, M_LW, 5'd29, 5'd4, 5'd0, 5'd0, 32'd8);
    cyc();
    chk("lw", bus.out_instr, 32'h8FA40008);
    chk("lw_addr", 32'(bus.out_addr), 32'd3);
    put(1'b1, M_JAL, 5'd0, 5'd0, 5'd0, 5'd0, 32'hC00);
    cyc();
    chk("jal", bus.out_instr, 32'h0C000C00);
    chk("jal_addr", 32'(bus.out_addr), 32'd4);
    put(1'b0, M_NOP, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    cyc();
    put(1'b1, 5'd31, 5'd1, 5'd1, 5'd1, 5'd1, 32'd1);
    cyc();
    put(1'b0, M_NOP, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    chk("bad_err", 32'(bus.err), 32'd1);
    chk("bad_valid", 32'(bus.out_valid), 32'd0);
    cyc();
    chk("bad_err_end", 32'(bus.err), 32'd0);
    put(1'b1, M_LI, 5'd0, 5'd7, 5'd0, 5'd0, 32'h0000BEEF);
    cyc();
    put(1'b0, M_NOP, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    chk("li_short", bus.out_instr, 32'h3407BEEF);
    cyc();
    bus.out_ready = 1'b0;
    put(1'b1, M_LI, 5'd0, 5'd5, 5'd0, 5'd0, 32'hABCD0001);
    cyc();
    put(1'b0, M_NOP, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    chk("rst_hi_instr", bus.out_instr, 32'h3C05ABCD);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    chk("rst_hi_valid", 32'(bus.out_valid), 32'd0);
    cyc();
    cyc();
    chk("rst_hi_no_ori", 32'(bus.out_valid), 32'd0);
    bus.addr_clr = 1'b1;
    cyc();
    bus.addr_clr = 1'b0;
    for (int i = 0; i < 1026; i++) begin
      put(1'b1, M_NOP, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0);
      cyc();
      if (i == 1023) chk("nop_last", 32'(bus.out_addr), 32'd1023);
      if (i == 1024) chk("nop_wrap", 32'(bus.out_addr), 32'd0);
    end
    bus.addr_clr = 1'b1;
    cyc();
    chk("clr_hs", 32'(bus.out_addr), 32'd0);
    bus.addr_clr = 1'b0;
    cyc();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    bus.addr_clr = 1'b1;
    cyc();
    chk("clr_held", 32'(bus.out_addr), 32'd1);
    bus.addr_clr = 1'b0;
    cyc();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    cyc();
    chk("clr_next", 32'(bus.out_addr), 32'd0);
    for (int i = 0; i < 600; i++) begin
      bus.in_valid = ($urandom % 4) != 0;
      bus.out_ready = ($urandom % 4) != 0;
      bus.addr_clr = ($urandom % 20) == 0;
      bus.in_mnem = ($urandom % 8 == 0) ? 5'(22 + $urandom % 10) : 5'($urandom % 22);
      bus.in_rs = 5'($urandom);
      bus.in_rt = 5'($urandom);
      bus.in_rd = 5'($urandom);
      bus.in_shamt = 5'($urandom);
      bus.in_imm = ($urandom % 4 == 0) ? ($urandom & 32'hFFFF) : $urandom;
      cyc();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.addr_clr = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    chk("drained", 32'(bus.out_valid), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
